// File: rtl/compass_spi_pkg.sv
// Shared definitions for the compass accelerometer SPI target model.
// Holds the command opcodes, the register map, reset values, the FSM state
// encoding and a register-read helper used by spi_accel_target.
package compass_spi_pkg;

  // Command opcodes (first byte of every transaction)
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  // Register map
  localparam logic [7:0] ADDR_DEVID      = 8'h00;
  localparam logic [7:0] ADDR_XL         = 8'h0E;
  localparam logic [7:0] ADDR_XH         = 8'h0F;
  localparam logic [7:0] ADDR_YL         = 8'h10;
  localparam logic [7:0] ADDR_YH         = 8'h11;
  localparam logic [7:0] ADDR_ZL         = 8'h12;
  localparam logic [7:0] ADDR_ZH         = 8'h13;
  localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
  localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

  // Reset values of the writable registers
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  // Read view of the register file. Unmapped addresses read as zero.
  function automatic logic [7:0] reg_value(
    input logic [7:0]  a,
    input logic [7:0]  devid,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] z,
    input logic [7:0]  filt,
    input logic [7:0]  pwr
  );
    case (a)
      ADDR_DEVID:      return devid;
      ADDR_XL:         return x[7:0];
      ADDR_XH:         return x[15:8];
      ADDR_YL:         return y[7:0];
      ADDR_YH:         return y[15:8];
      ADDR_ZL:         return z[7:0];
      ADDR_ZH:         return z[15:8];
      ADDR_FILTER_CTL: return filt;
      ADDR_POWER_CTL:  return pwr;
      default:         return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized copy.
// Ports:
//   iclk   in  system clock
//   reset  in  asynchronous active-high reset
//   d      in  asynchronous input
//   level  out synchronized level (STAGES iclk behind d)
//   rise   out one-cycle pulse when level goes 0->1
//   fall   out one-cycle pulse when level goes 1->0
// All flops reset to 0. For chip select this means a cs held low through
// reset is never mistaken for a new falling edge: the line must first be
// seen high before a fall can be reported.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic iclk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_accel_target.sv
// SPI target (mode 0, MSB first) modelling the compass 3-axis accelerometer.
// Protocol: command byte (0x0B read / 0x0A write), address byte, then burst
// data with address auto-increment. Axis data is snapshotted at cs fall.
// Ports:
//   iclk, reset           system clock, asynchronous active-high reset
//   cs, sclk, mosi        SPI pins from the master (asynchronous to iclk)
//   miso                  SPI data to the master, 0 while cs is high
//   x_data/y_data/z_data  16-bit axis samples
//   power_ctl, filter_ctl writable control registers (0x2D, 0x2C)
//   busy                  high while a transaction is in progress
//   txn_done              one-iclk pulse at cs rise after a complete command byte
module spi_accel_target
  import compass_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_VAL   = 8'hAD,
  parameter int         ADDR_W      = 6
) (
  input  logic        iclk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        busy,
  output logic        txn_done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  // Synchronized pins and edges
  logic cs_rise, cs_fall, cs_level_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .iclk(iclk), .reset(reset), .d(cs),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .iclk(iclk), .reset(reset), .d(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .iclk(iclk), .reset(reset), .d(mosi),
    .level(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // State and its next-state values
  state_t            state, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [7:0]        rx, rx_d;
  logic [7:0]        tx, tx_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              is_read, is_read_d;
  logic              cmd_done, cmd_done_d;
  logic              miso_r, miso_d;
  logic              txn_done_d;
  logic [15:0]       snap_x, snap_y, snap_z;
  logic [15:0]       snap_x_d, snap_y_d, snap_z_d;
  logic [7:0]        power_d, filter_d;

  // Helpers evaluated in the next-state logic
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_rx;

  assign rx_byte  = {rx[6:0], mosi_q};
  assign addr_inc = addr + ADDR_ONE;
  assign addr_rx  = rx_byte[ADDR_W-1:0];

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      addr       <= '0;
      is_read    <= 1'b0;
      cmd_done   <= 1'b0;
      miso_r     <= 1'b0;
      txn_done   <= 1'b0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_z     <= '0;
      power_ctl  <= POWER_CTL_RST;
      filter_ctl <= FILTER_CTL_RST;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      rx         <= rx_d;
      tx         <= tx_d;
      addr       <= addr_d;
      is_read    <= is_read_d;
      cmd_done   <= cmd_done_d;
      miso_r     <= miso_d;
      txn_done   <= txn_done_d;
      snap_x     <= snap_x_d;
      snap_y     <= snap_y_d;
      snap_z     <= snap_z_d;
      power_ctl  <= power_d;
      filter_ctl <= filter_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold default first so no path through the
    // case statement can leave a value unassigned and infer a latch.
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    rx_d       = rx;
    tx_d       = tx;
    addr_d     = addr;
    is_read_d  = is_read;
    cmd_done_d = cmd_done;
    miso_d     = miso_r;
    txn_done_d = 1'b0;
    snap_x_d   = snap_x;
    snap_y_d   = snap_y;
    snap_z_d   = snap_z;
    power_d    = power_ctl;
    filter_d   = filter_ctl;

    if (cs_rise) begin
      // End of transaction from any state; a partial byte is simply dropped.
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
      txn_done_d = cmd_done;
      cmd_done_d = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            snap_x_d  = x_data;
            snap_y_d  = y_data;
            snap_z_d  = z_data;
            // An sclk rise coincident with cs fall is bit 0 of the command.
            if (sclk_rise) begin
              rx_d      = rx_byte;
              bit_cnt_d = 3'd1;
            end
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              cmd_done_d = 1'b1;
              if (rx_byte == CMD_READ) begin
                is_read_d = 1'b1;
                state_d   = ST_ADDR;
              end else if (rx_byte == CMD_WRITE) begin
                is_read_d = 1'b0;
                state_d   = ST_ADDR;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR: begin
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr_d  = addr_rx;
              state_d = ST_DATA;
              // Preloaded for reads; unused (and harmless) for writes.
              tx_d    = reg_value(8'(addr_rx), DEVID_VAL, snap_x, snap_y,
                                  snap_z, filter_ctl, power_ctl);
            end
          end
        end

        ST_DATA: begin
          if (sclk_fall && is_read) begin
            miso_d = tx[7];
            tx_d   = {tx[6:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!is_read) begin
                if (8'(addr) == ADDR_FILTER_CTL) filter_d = rx_byte;
                if (8'(addr) == ADDR_POWER_CTL)  power_d  = rx_byte;
              end
              addr_d = addr_inc;
              tx_d   = reg_value(8'(addr_inc), DEVID_VAL, snap_x, snap_y,
                                 snap_z, filter_ctl, power_ctl);
            end
          end
        end

        ST_IGNORE: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Gate with the raw pin so miso is low the moment cs deasserts, without
  // waiting for the synchronized cs_rise to clear miso_r.
  assign miso = miso_r & ~cs;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_accel_target.sv
// Directed self-checking bench for spi_accel_target (SPI mode 0 master model).
module tb_spi_accel_target;

  localparam int HALF = 8;  // sclk half period in iclk cycles

  logic        iclk = 1'b0;
  logic        reset;
  logic        cs, sclk, mosi;
  logic        miso;
  logic [15:0] x_data, y_data, z_data;
  logic [7:0]  power_ctl, filter_ctl;
  logic        busy, txn_done;

  int errors = 0;
  int checks = 0;

  spi_accel_target #(
    .SYNC_STAGES(2),
    .DEVID_VAL(8'hAD),
    .ADDR_W(6)
  ) dut (
    .iclk(iclk),
    .reset(reset),
    .cs(cs),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .x_data(x_data),
    .y_data(y_data),
    .z_data(z_data),
    .power_ctl(power_ctl),
    .filter_ctl(filter_ctl),
    .busy(busy),
    .txn_done(txn_done)
  );

  always #5 iclk = ~iclk;

  // ---------------- SPI master primitives ----------------
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge iclk);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      repeat (HALF) @(negedge iclk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    repeat (HALF) @(negedge iclk);
  endtask

  // Raise cs and report whether txn_done pulsed within a bounded window.
  task automatic cs_end(output logic seen);
    repeat (HALF) @(negedge iclk);
    cs = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge iclk);
      if (txn_done) seen = 1'b1;
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_data = 16'h0000; y_data = 16'h0000; z_data = 16'h0000;
    repeat (5) @(negedge iclk);
    reset = 1'b0;
    repeat (6) @(negedge iclk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (txn_done !== 1'b0) begin errors++; $display("FAIL reset_txn_done got=%b exp=0", txn_done); end
    checks++; if (power_ctl !== 8'h00) begin errors++; $display("FAIL reset_power got=%h exp=00", power_ctl); end
    checks++; if (filter_ctl !== 8'h13) begin errors++; $display("FAIL reset_filter got=%h exp=13", filter_ctl); end
  endtask

  task automatic test_read_devid();
    logic [7:0] rx;
    logic seen;
    cs_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL devid_busy got=%b exp=1", busy); end
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL devid_byte got=%h exp=AD", rx); end
    cs_end(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL devid_txn_done got=%b exp=1", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL devid_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_burst_read();
    logic [7:0] rx;
    logic [7:0] exp_bytes [6];
    logic seen;
    exp_bytes = '{8'h23, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h01};
    x_data = 16'h0123; y_data = 16'hFF80; z_data = 16'h0100;
    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) x_data = 16'h0555;  // must not disturb this burst
      spi_bits(8'h00, 8, rx);
      checks++;
      if (rx !== exp_bytes[i]) begin
        errors++; $display("FAIL burst_byte%0d got=%h exp=%h", i, rx, exp_bytes[i]);
      end
    end
    cs_end(seen);
    // A new transaction picks up the changed X sample.
    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h55) begin errors++; $display("FAIL burst_new_snapshot got=%h exp=55", rx); end
    cs_end(seen);
  endtask

  task automatic test_write_read();
    logic [7:0] rx;
    logic seen;
    cs_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h02, 8, rx);
    cs_end(seen);
    checks++; if (power_ctl !== 8'h02) begin errors++; $display("FAIL write_power got=%h exp=02", power_ctl); end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL write_txn_done got=%b exp=1", seen); end

    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_end(seen);
    checks++; if (rx !== 8'h02) begin errors++; $display("FAIL readback_power got=%h exp=02", rx); end

    // Write to read-only DEVID is dropped.
    cs_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h55, 8, rx);
    cs_end(seen);
    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_end(seen);
    checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL devid_readonly got=%h exp=AD", rx); end

    // Burst write across 0x2C -> 0x2D.
    cs_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2C, 8, rx);
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h09, 8, rx);
    cs_end(seen);
    checks++; if (filter_ctl !== 8'h07) begin errors++; $display("FAIL burst_write_filter got=%h exp=07", filter_ctl); end
    checks++; if (power_ctl !== 8'h09) begin errors++; $display("FAIL burst_write_power got=%h exp=09", power_ctl); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic seen;
    // Abort inside the write data byte: no write, but command was complete.
    cs_start();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'hF0, 4, rx);
    cs_end(seen);
    checks++; if (power_ctl !== 8'h09) begin errors++; $display("FAIL abort_power got=%h exp=09", power_ctl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", busy); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso got=%b exp=0", miso); end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_txn_done got=%b exp=1", seen); end
    // Abort inside the command byte: no txn_done.
    cs_start();
    spi_bits(8'h0B, 4, rx);
    cs_end(seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_cmd_txn_done got=%b exp=0", seen); end
  endtask

  task automatic test_wrap_and_ignore();
    logic [7:0] rx;
    logic seen;
    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h3F, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_byte0 got=%h exp=00", rx); end
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL wrap_byte1 got=%h exp=AD", rx); end
    cs_end(seen);

    cs_start();
    spi_bits(8'h55, 8, rx);
    spi_bits(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL ignore_byte0 got=%h exp=00", rx); end
    spi_bits(8'hFF, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL ignore_byte1 got=%h exp=00", rx); end
    cs_end(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ignore_txn_done got=%b exp=1", seen); end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] rx;
    logic seen;
    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 2, rx);  // two DEVID bits; the following fall drives bit 5 (=1)
    repeat (4) @(negedge iclk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL mid_pre_reset_miso got=%b exp=1", miso); end
    reset = 1'b1;
    repeat (2) @(negedge iclk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mid_reset_miso got=%b exp=0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    checks++; if (power_ctl !== 8'h00) begin errors++; $display("FAIL mid_reset_power got=%h exp=00", power_ctl); end
    checks++; if (filter_ctl !== 8'h13) begin errors++; $display("FAIL mid_reset_filter got=%h exp=13", filter_ctl); end
    reset = 1'b0;
    // cs still low: target must stay idle and ignore these clocks.
    spi_bits(8'hFF, 8, rx);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", busy); end
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL post_reset_miso got=%h exp=00", rx); end
    cs_end(seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL post_reset_txn_done got=%b exp=0", seen); end
    // A fresh, complete transaction works.
    cs_start();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_end(seen);
    checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL recover_devid got=%h exp=AD", rx); end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL recover_txn_done got=%b exp=1", seen); end
  endtask

  initial begin
    test_reset();
    test_read_devid();
    test_burst_read();
    test_write_read();
    test_abort();
    test_wrap_and_ignore();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
